// File: rtl/acc_datapath.sv
// Datapath for the accumulator machine: PC, IR, ACC/carry and a multi-cycle
// restoring divider, steered by the controller's strobes.
module acc_datapath #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_ir,
   input  logic              load_acc,
   input  logic              sel_bus,
   input  logic              pass_add,
   input  logic              div_pass,
   input  logic              ld_pc,
   input  logic              clr_pc,
   input  logic              inc_pc,
   input  logic              ir_on_adr,
   input  logic              pc_on_adr,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [2:0]        opcode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] acc_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              carry,
   output logic [DATA_W-1:0] rem_out,
   output logic              div_busy,
   output logic              div_done,
   output logic              div_zero,
   output logic [1:0]        div_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] acc;
   logic              carry_q;
   logic [DATA_W-1:0] rem_q;
   logic              div_zero_q;
   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] dvs;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] part;
   logic              zero_div;

   logic              busy;
   logic              finish;
   logic              acc_load;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   diff;
   logic              fits;
   logic [DATA_W:0]   sum;

   assign busy     = (state != S_IDLE);
   assign finish   = (state == S_RUN) && (cnt == CNT_LAST);
   assign acc_load = load_acc & sel_bus;
   assign sum      = {1'b0, acc} + {1'b0, mem_rdata};

   // Partial remainder stays below the divisor, so the sign bit of diff
   // alone tells whether the shifted value covers the divisor.
   assign shifted = {part, quo[DATA_W-1]};
   assign diff    = shifted - {1'b0, dvs};
   assign fits    = ~diff[DATA_W];

   always_comb begin
      mem_addr = '0;
      if (ir_on_adr)
         mem_addr = ir[ADDR_W-1:0];
      else if (pc_on_adr)
         mem_addr = pc;
   end

   assign mem_re    = mem_read;
   assign mem_we    = mem_write & ~busy;
   assign mem_wdata = acc;
   assign opcode    = ir[DATA_W-1:DATA_W-3];
   assign acc_out   = acc;
   assign pc_out    = pc;
   assign carry     = carry_q;
   assign rem_out   = rem_q;
   assign div_busy  = busy;
   assign div_done  = (state == S_DONE);
   assign div_zero  = div_zero_q;
   assign div_state = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         ir <= '0;
      else if (load_ir)
         ir <= mem_rdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pc <= '0;
      else if (clr_pc)
         pc <= '0;
      else if (inc_pc)
         pc <= pc + PC_ONE;
      else if (ld_pc)
         pc <= ir[ADDR_W-1:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc        <= '0;
         carry_q    <= 1'b0;
         rem_q      <= '0;
         div_zero_q <= 1'b0;
      end else if (finish) begin
         acc        <= quo;
         rem_q      <= part;
         div_zero_q <= zero_div;
      end else if (!busy) begin
         if (acc_load)
            acc <= mem_rdata;
         else if (pass_add)
            {carry_q, acc} <= sum;
      end
   end

   // A zero divisor skips the step phase: counter preset to its last value
   // so the very next edge writes the saturated result.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         dvs      <= '0;
         quo      <= '0;
         part     <= '0;
         zero_div <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (div_pass && !acc_load && !pass_add) begin
                  dvs   <= mem_rdata;
                  state <= S_RUN;
                  if (mem_rdata == '0) begin
                     quo      <= '1;
                     part     <= acc;
                     cnt      <= CNT_LAST;
                     zero_div <= 1'b1;
                  end else begin
                     quo      <= acc;
                     part     <= '0;
                     cnt      <= '0;
                     zero_div <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (cnt == CNT_LAST) begin
                  state <= S_DONE;
               end else begin
                  part <= fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
                  quo  <= {quo[DATA_W-2:0], fits};
                  cnt  <= cnt + CNT_ONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_datapath.sv
// Directed bench for acc_datapath: a vector table for single-cycle behaviour
// and hand-written sequences for divide timing, zero divisor and reset abort.
module tb_acc_datapath;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   localparam logic [11:0] DIV  = 12'h800;
   localparam logic [11:0] LIR  = 12'h400;
   localparam logic [11:0] LACC = 12'h200;
   localparam logic [11:0] SEL  = 12'h100;
   localparam logic [11:0] ADD  = 12'h080;
   localparam logic [11:0] LDPC = 12'h040;
   localparam logic [11:0] CLR  = 12'h020;
   localparam logic [11:0] INC  = 12'h010;
   localparam logic [11:0] IRA  = 12'h008;
   localparam logic [11:0] PCA  = 12'h004;
   localparam logic [11:0] RD   = 12'h002;
   localparam logic [11:0] WR   = 12'h001;

   typedef struct {
      logic [11:0]       ctrl;
      logic [DATA_W-1:0] rdata;
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_re;
      logic              exp_we;
      logic [DATA_W-1:0] exp_acc;
      logic [ADDR_W-1:0] exp_pc;
      logic              exp_carry;
      logic [2:0]        exp_op;
   } vec_t;

   logic              clock = 1'b0;
   logic              reset;
   logic              load_ir, load_acc, sel_bus, pass_add, div_pass;
   logic              ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr;
   logic              mem_read, mem_write;
   logic [DATA_W-1:0] mem_rdata;
   logic [2:0]        opcode;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re, mem_we;
   logic [DATA_W-1:0] acc_out;
   logic [ADDR_W-1:0] pc_out;
   logic              carry;
   logic [DATA_W-1:0] rem_out;
   logic              div_busy, div_done, div_zero;
   logic [1:0]        div_state;

   int n_checks = 0;
   int n_fail   = 0;

   acc_datapath #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .load_ir(load_ir), .load_acc(load_acc), .sel_bus(sel_bus),
      .pass_add(pass_add), .div_pass(div_pass),
      .ld_pc(ld_pc), .clr_pc(clr_pc), .inc_pc(inc_pc),
      .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
      .opcode(opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_we(mem_we), .acc_out(acc_out), .pc_out(pc_out),
      .carry(carry), .rem_out(rem_out), .div_busy(div_busy),
      .div_done(div_done), .div_zero(div_zero), .div_state(div_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic [11:0] c, input logic [DATA_W-1:0] d);
      @(negedge clock);
      {div_pass, load_ir, load_acc, sel_bus, pass_add, ld_pc, clr_pc, inc_pc,
       ir_on_adr, pc_on_adr, mem_read, mem_write} = c;
      mem_rdata = d;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   vec_t vecs[19];
   int   busy_cycles, done_cnt, done_at;

   initial begin
      vecs[0]  = '{INC|PCA,       8'h00, 5'h00, 0, 0, 8'h00, 5'h01, 0, 3'd0};
      vecs[1]  = '{INC|PCA,       8'h00, 5'h01, 0, 0, 8'h00, 5'h02, 0, 3'd0};
      vecs[2]  = '{INC|PCA,       8'h00, 5'h02, 0, 0, 8'h00, 5'h03, 0, 3'd0};
      vecs[3]  = '{CLR|PCA,       8'h00, 5'h03, 0, 0, 8'h00, 5'h00, 0, 3'd0};
      vecs[4]  = '{LACC|SEL,      8'hF0, 5'h00, 0, 0, 8'hF0, 5'h00, 0, 3'd0};
      vecs[5]  = '{ADD,           8'h20, 5'h00, 0, 0, 8'h10, 5'h00, 1, 3'd0};
      vecs[6]  = '{ADD,           8'h01, 5'h00, 0, 0, 8'h11, 5'h00, 0, 3'd0};
      vecs[7]  = '{LACC,          8'h77, 5'h00, 0, 0, 8'h11, 5'h00, 0, 3'd0};
      vecs[8]  = '{SEL,           8'h66, 5'h00, 0, 0, 8'h11, 5'h00, 0, 3'd0};
      vecs[9]  = '{LIR,           8'h5A, 5'h00, 0, 0, 8'h11, 5'h00, 0, 3'd2};
      vecs[10] = '{IRA|PCA|RD,    8'h00, 5'h1A, 1, 0, 8'h11, 5'h00, 0, 3'd2};
      vecs[11] = '{LDPC,          8'h00, 5'h00, 0, 0, 8'h11, 5'h1A, 0, 3'd2};
      vecs[12] = '{LDPC|INC|PCA,  8'h00, 5'h1A, 0, 0, 8'h11, 5'h1B, 0, 3'd2};
      vecs[13] = '{LIR|WR,        8'h1F, 5'h00, 0, 1, 8'h11, 5'h1B, 0, 3'd0};
      vecs[14] = '{LDPC|IRA,      8'h00, 5'h1F, 0, 0, 8'h11, 5'h1F, 0, 3'd0};
      vecs[15] = '{INC|PCA,       8'h00, 5'h1F, 0, 0, 8'h11, 5'h00, 0, 3'd0};
      vecs[16] = '{ADD|LACC|SEL,  8'hFF, 5'h00, 0, 0, 8'hFF, 5'h00, 0, 3'd0};
      vecs[17] = '{ADD,           8'h02, 5'h00, 0, 0, 8'h01, 5'h00, 1, 3'd0};
      vecs[18] = '{LACC|SEL,      8'h00, 5'h00, 0, 0, 8'h00, 5'h00, 1, 3'd0};

      // clock/reset
      reset = 1'b1;
      {div_pass, load_ir, load_acc, sel_bus, pass_add, ld_pc, clr_pc, inc_pc,
       ir_on_adr, pc_on_adr, mem_read, mem_write} = '0;
      mem_rdata = '0;
      #12;
      check("rst_acc", 32'(acc_out), 0);
      check("rst_pc", 32'(pc_out), 0);
      check("rst_opcode", 32'(opcode), 0);
      check("rst_wdata", 32'(mem_wdata), 0);
      check("rst_flags", {28'd0, carry, div_busy, div_done, div_zero}, 0);
      check("rst_rem", 32'(rem_out), 0);
      check("rst_bus", {26'd0, mem_addr, mem_re}, 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_state", 32'(div_state), 0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         apply(vecs[i].ctrl, vecs[i].rdata);
         #1;
         check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
         check($sformatf("v%0d_re", i), 32'(mem_re), 32'(vecs[i].exp_re));
         check($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
         step();
         check($sformatf("v%0d_acc", i), 32'(acc_out), 32'(vecs[i].exp_acc));
         check($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].exp_acc));
         check($sformatf("v%0d_pc", i), 32'(pc_out), 32'(vecs[i].exp_pc));
         check($sformatf("v%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
         check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].exp_op));
      end

      // 200 / 7 = 28 rem 4, with a stray add and write mid-divide
      apply(LACC|SEL, 8'd200);
      step();
      apply(DIV, 8'd7);
      step();
      check("div_busy_e0", 32'(div_busy), 1);
      busy_cycles = 1;
      done_cnt = 0;
      done_at = -1;
      for (int k = 1; k <= 20; k++) begin
         apply((k == 3) ? (ADD|WR) : 12'h000, 8'd7);
         if (k == 3) begin
            #1;
            check("div_we_blocked", 32'(mem_we), 0);
         end
         step();
         if (div_busy) busy_cycles++;
         if (div_done) begin
            done_cnt++;
            done_at = k;
            check("div_acc_at_done", 32'(acc_out), 28);
            check("div_rem_at_done", 32'(rem_out), 4);
         end
      end
      check("div_busy_cycles", busy_cycles, 10);
      check("div_done_pulses", done_cnt, 1);
      check("div_done_edge", done_at, DATA_W + 1);
      check("div_acc_after", 32'(acc_out), 28);
      check("div_zero_flag", 32'(div_zero), 0);

      // zero divisor
      apply(LACC|SEL, 8'd55);
      step();
      apply(DIV, 8'd0);
      step();
      check("dz_busy_e0", 32'(div_busy), 1);
      check("dz_done_e0", 32'(div_done), 0);
      apply(WR, 8'd0);
      #1;
      check("dz_we_blocked", 32'(mem_we), 0);
      step();
      check("dz_done_e1", 32'(div_done), 1);
      check("dz_acc", 32'(acc_out), 32'hFF);
      check("dz_rem", 32'(rem_out), 55);
      check("dz_flag", 32'(div_zero), 1);
      apply(12'h000, 8'd0);
      step();
      check("dz_busy_e2", 32'(div_busy), 0);
      check("dz_done_e2", 32'(div_done), 0);
      check("dz_acc_hold", 32'(acc_out), 32'hFF);

      // reset during RUN aborts the divide
      apply(LACC|SEL, 8'd100);
      step();
      apply(DIV, 8'd3);
      step();
      apply(12'h000, 8'd0);
      step();
      step();
      check("ra_busy_before", 32'(div_busy), 1);
      #2;
      reset = 1'b1;
      #1;
      check("ra_busy", 32'(div_busy), 0);
      check("ra_acc", 32'(acc_out), 0);
      check("ra_zero_rem", {23'd0, div_zero, rem_out}, 0);
      check("ra_state", 32'(div_state), 0);
      @(negedge clock);
      reset = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (div_done) done_cnt++;
      end
      check("ra_no_done", done_cnt, 0);
      check("ra_acc_after", 32'(acc_out), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
